multi_drop_bus_regfile: RTL
===========================

Name: multi_drop_bus_regfile

Overview:
Parametrised multi-drop bus register bank with NUM_REGS registers of WIDTH bits on one shared bus. Registers load from an external data source via one-hot enables. The block also supports register-to-register transfers over the internal bus, run by a 3-state FSM. Sticky error flags catch illegal enable patterns and collisions. It sits between a bus master and datapath consumers that read the flattened register outputs.

Parameters:
WIDTH, 16, data/register width in bits (>=1)
NUM_REGS, 4, number of bus-attached registers (>=2)
SELW, $clog2(NUM_REGS), local parameter: select index width (not overridable)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
ext_data  input  WIDTH  external data driven onto the bus for loads
load_en  input  NUM_REGS  one-hot load enable; bit i selects register i
xfer_req  input  1  request register-to-register transfer
xfer_src  input  SELW  transfer source index
xfer_dst  input  SELW  transfer destination index
err_clr  input  1  clears sticky error flags
regs  output  NUM_REGS*WIDTH  flattened registers; register i at [i*WIDTH +: WIDTH]
bus_out  output  WIDTH  registered internal bus value
busy  output  1  transfer in progress (state != IDLE), combinational from state
xfer_done  output  1  one-cycle pulse: transfer completed
sel_err  output  1  sticky: illegal select seen
coll_err  output  1  sticky: load or request ignored because of a busy or accepted transfer

Behaviour:
- Reset (async, Reset=0): all regs=0, bus_out=0, state=IDLE, xfer_done=0, sel_err=0, coll_err=0. A transfer in flight is aborted and no destination write occurs.
- FSM states: IDLE, XFER_RD, XFER_WR.
- IDLE, xfer_req=1, both indices < NUM_REGS: latch src/dst, go to XFER_RD. Any nonzero load_en in the same cycle is ignored and sets coll_err. Transfer has priority.
- IDLE, xfer_req=1, either index >= NUM_REGS: reject, stay in IDLE, set sel_err. A one-hot load_en in the same cycle is still performed.
- IDLE, xfer_req=0, load_en one-hot: regs[i] <= ext_data and bus_out <= ext_data, in the same edge.
- IDLE, load_en nonzero and not one-hot: no register written, bus_out holds, sel_err set.
- load_en=0 with no request: everything holds.
- XFER_RD: bus_out <= regs[src], then go to XFER_WR.
- XFER_WR: regs[dst] <= bus_out, xfer_done <= 1, then go to IDLE.
- xfer_done is high for exactly one cycle, with the updated regs visible. It is 0 at every other time.
- Latency: request sampled at edge t. bus_out is updated at t+1, regs[dst] at t+2, and xfer_done is high in the cycle after t+2. busy is high for 2 cycles.
- src==dst is legal: the register rewrites its own value and xfer_done pulses.
- Back-to-back: a new xfer_req is accepted in the same cycle xfer_done is high, since the FSM is in IDLE.
- While busy: any xfer_req or nonzero load_en is ignored and sets coll_err. No queueing.
- err_clr=1 clears both flags. If a new error occurs in the same cycle, that flag is set (set wins).
- Registers not addressed always hold their value.

Test Plan:
1. Reset low mid-XFER_RD (NUM_REGS=4, WIDTH=16) -> all regs, bus_out, flags and xfer_done are 0 immediately; the destination is never written after Reset releases.
2. load_en=4'b0001..4'b1000 with ext_data=16'h0088, 16'h0077, 16'h1234, 16'hBEEF -> regs[0..3] hold those values; bus_out tracks each load on the same edge; flags stay 0.
3. load_en=4'b0011 and 4'b1111 with ext_data=16'hFFFF -> no register changes, sel_err=1. err_clr pulse -> sel_err=0.
4. regs[2]=16'h1234, xfer_req with src=2, dst=0 -> busy high 2 cycles, bus_out=16'h1234 after 1 edge, regs[0]=16'h1234 after 2 edges, xfer_done high for 1 cycle.
5. Transfer in flight, load_en=4'b0100 with ext_data=16'hAAAA -> regs[2] unchanged, coll_err=1. xfer_req and load_en together in IDLE -> transfer accepted, load dropped, coll_err=1.
6. NUM_REGS=3: xfer_req with src=3 -> rejected, sel_err=1, busy stays 0. Second run with WIDTH=8, NUM_REGS=8: loads and a src=7, dst=0 transfer are correct.

Source files
------------

// File: rtl/multi_drop_bus_regfile.sv
// Multi-drop bus register bank.
// NUM_REGS registers of WIDTH bits share one internal bus. Registers are
// loaded from ext_data through one-hot enables, or copied register-to-register
// by a three-state transfer FSM (IDLE -> XFER_RD -> XFER_WR). Sticky flags
// record illegal selects and loads/requests dropped because of a transfer.
module multi_drop_bus_regfile #(
  parameter int  WIDTH    = 16,
  parameter int  NUM_REGS = 4,
  localparam int SELW     = $clog2(NUM_REGS)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [WIDTH-1:0]          ext_data,
  input  logic [NUM_REGS-1:0]       load_en,
  input  logic                      xfer_req,
  input  logic [SELW-1:0]           xfer_src,
  input  logic [SELW-1:0]           xfer_dst,
  input  logic                      err_clr,
  output logic [NUM_REGS*WIDTH-1:0] regs,
  output logic [WIDTH-1:0]          bus_out,
  output logic                      busy,
  output logic                      xfer_done,
  output logic                      sel_err,
  output logic                      coll_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER_RD = 2'd1,
    XFER_WR = 2'd2
  } state_t;

  // Register count widened by one bit so indices can be range-checked even
  // when NUM_REGS is not a power of two.
  localparam logic [SELW:0] NREGS_W = (SELW+1)'(NUM_REGS);

  state_t                             state_q, state_d;
  logic [SELW-1:0]                    src_q, src_d;
  logic [SELW-1:0]                    dst_q, dst_d;
  logic [NUM_REGS-1:0][WIDTH-1:0]     regs_q, regs_d;
  logic [WIDTH-1:0]                   bus_q, bus_d;
  logic                               done_q, done_d;
  logic                               sel_q, sel_d;
  logic                               coll_q, coll_d;
  logic                               sel_set_s;
  logic                               coll_set_s;
  logic                               src_ok_s;
  logic                               dst_ok_s;
  logic                               load_any_s;
  logic                               load_onehot_s;

  assign src_ok_s      = ({1'b0, xfer_src} < NREGS_W);
  assign dst_ok_s      = ({1'b0, xfer_dst} < NREGS_W);
  assign load_any_s    = |load_en;
  assign load_onehot_s = $onehot(load_en);

  // Next-state, datapath and error-event decode for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    regs_d     = regs_q;
    bus_d      = bus_q;
    done_d     = 1'b0;
    sel_set_s  = 1'b0;
    coll_set_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_req && src_ok_s && dst_ok_s) begin
          // Transfer wins; any load presented alongside it is dropped.
          state_d    = XFER_RD;
          src_d      = xfer_src;
          dst_d      = xfer_dst;
          coll_set_s = load_any_s;
        end else begin
          // A rejected request does not block a legal one-hot load.
          sel_set_s = xfer_req | (load_any_s & ~load_onehot_s);
          if (load_onehot_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              regs_d[i] = load_en[i] ? ext_data : regs_q[i];
            end
            bus_d = ext_data;
          end else begin
            bus_d = bus_q;
          end
        end
      end
      XFER_RD: begin
        bus_d      = regs_q[src_q];
        state_d    = XFER_WR;
        coll_set_s = xfer_req | load_any_s;
      end
      XFER_WR: begin
        regs_d[dst_q] = bus_q;
        done_d        = 1'b1;
        state_d       = IDLE;
        coll_set_s    = xfer_req | load_any_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Sticky flags: a new event in the clearing cycle keeps the flag set.
    sel_d  = sel_set_s  | (sel_q  & ~err_clr);
    coll_d = coll_set_s | (coll_q & ~err_clr);
  end

  // State, register bank and flag storage with asynchronous reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      src_q   <= {SELW{1'b0}};
      dst_q   <= {SELW{1'b0}};
      regs_q  <= {(NUM_REGS*WIDTH){1'b0}};
      bus_q   <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      regs_q  <= regs_d;
      bus_q   <= bus_d;
      done_q  <= done_d;
      sel_q   <= sel_d;
      coll_q  <= coll_d;
    end
  end

  assign regs      = regs_q;
  assign bus_out   = bus_q;
  assign busy      = (state_q != IDLE);
  assign xfer_done = done_q;
  assign sel_err   = sel_q;
  assign coll_err  = coll_q;

endmodule
